// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with level-sensitive interrupts, trap entry and mret.
// Trap entry beats mret and CSR ops; mret overrides MIE/MPIE after a CSR op.
module csr_trap_unit #(
  parameter int          NUM_IRQ   = 4,
  parameter logic [31:0] MTVEC_RST = 32'h0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_IRQ-1:0] IRQ,
  input  logic [11:0]        ADDR,
  input  logic [1:0]         OP,
  input  logic [31:0]        WD,
  input  logic [31:0]        PC,
  input  logic               INT_TAKEN,
  input  logic               MRET,
  output logic [31:0]        RD,
  output logic [31:0]        CSR_MEPC,
  output logic [31:0]        CSR_MTVEC,
  output logic               INT_PEND,
  output logic               ILLEGAL
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;

  logic               status_mie;
  logic               status_mpie;
  logic [NUM_IRQ-1:0] mie_en;
  logic [NUM_IRQ-1:0] mip;
  logic [31:0]        mtvec;
  logic [31:0]        mscratch;
  logic [31:0]        mepc;
  logic               mcause_int;
  logic [3:0]         mcause_code;
  logic [63:0]        mcycle;

  logic [31:0]        old_val;
  logic [31:0]        new_val;
  logic               writable;
  logic               wr_en;
  logic [NUM_IRQ-1:0] active;
  logic [3:0]         cause;
  logic [63:0]        mcycle_nxt;

  always_comb begin
    old_val  = 32'h0;
    writable = 1'b0;
    case (ADDR)
      A_MSTATUS: begin
        old_val  = {24'h0, status_mpie, 3'b000, status_mie, 3'b000};
        writable = 1'b1;
      end
      A_MIE: begin
        old_val  = 32'(mie_en);
        writable = 1'b1;
      end
      A_MTVEC: begin
        old_val  = mtvec;
        writable = 1'b1;
      end
      A_MSCRATCH: begin
        old_val  = mscratch;
        writable = 1'b1;
      end
      A_MEPC: begin
        old_val  = mepc;
        writable = 1'b1;
      end
      A_MCAUSE: begin
        old_val  = {mcause_int, 27'h0, mcause_code};
        writable = 1'b1;
      end
      A_MIP: old_val = 32'(mip);
      A_MCYCLE: begin
        old_val  = mcycle[31:0];
        writable = 1'b1;
      end
      A_MCYCLEH: begin
        old_val  = mcycle[63:32];
        writable = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (OP)
      2'b01:   new_val = WD;
      2'b10:   new_val = old_val | WD;
      2'b11:   new_val = old_val & ~WD;
      default: new_val = old_val;
    endcase
  end

  assign RD        = old_val;
  assign ILLEGAL   = (OP != 2'b00) && !writable;
  assign wr_en     = (OP != 2'b00) && writable && !INT_TAKEN;
  assign active    = mip & mie_en;
  assign INT_PEND  = status_mie & (|active);
  assign CSR_MEPC  = mepc;
  assign CSR_MTVEC = mtvec;

  // Lowest-numbered pending and enabled line wins.
  always_comb begin
    cause = 4'h0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) cause = 4'(i);
    end
  end

  always_comb begin
    mcycle_nxt = mcycle + 64'h1;
    if (wr_en && ADDR == A_MCYCLE)  mcycle_nxt = {mcycle[63:32], new_val};
    if (wr_en && ADDR == A_MCYCLEH) mcycle_nxt = {new_val, mcycle[31:0]};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      status_mie  <= 1'b0;
      status_mpie <= 1'b0;
      mie_en      <= '0;
      mip         <= '0;
      mtvec       <= MTVEC_RST;
      mscratch    <= 32'h0;
      mepc        <= 32'h0;
      mcause_int  <= 1'b0;
      mcause_code <= 4'h0;
      mcycle      <= 64'h0;
    end else begin
      mip    <= IRQ;
      mcycle <= mcycle_nxt;
      if (INT_TAKEN) begin
        mepc        <= PC & 32'hFFFF_FFFC;
        status_mpie <= status_mie;
        status_mie  <= 1'b0;
        if (INT_PEND) begin
          mcause_int  <= 1'b1;
          mcause_code <= cause;
        end
      end else begin
        if (wr_en) begin
          case (ADDR)
            A_MSTATUS: begin
              status_mie  <= new_val[3];
              status_mpie <= new_val[7];
            end
            A_MIE:      mie_en <= new_val[NUM_IRQ-1:0];
            A_MTVEC:    mtvec <= new_val;
            A_MSCRATCH: mscratch <= new_val;
            A_MEPC:     mepc <= new_val & 32'hFFFF_FFFC;
            A_MCAUSE: begin
              mcause_int  <= new_val[31];
              mcause_code <= new_val[3:0];
            end
            default: ;
          endcase
        end
        // mret sees MPIE as just written by a same-cycle mstatus op.
        if (MRET) begin
          status_mie  <= (wr_en && ADDR == A_MSTATUS) ? new_val[7] : status_mpie;
          status_mpie <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: directed trap/mret/counter scenarios
// plus randomized traffic against a word-level CSR reference model.
module tb_csr_trap_unit;

  localparam int          NUM_IRQ   = 4;
  localparam logic [31:0] MTVEC_RST = 32'h0000_1000;
  localparam logic [31:0] IRQ_MASK  = (32'h1 << NUM_IRQ) - 32'h1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NUM_IRQ-1:0] irq = '0;
  logic [11:0]        addr = 12'h0;
  logic [1:0]         op = 2'b00;
  logic [31:0]        wd = 32'h0;
  logic [31:0]        pc = 32'h0;
  logic               int_taken = 1'b0;
  logic               mret = 1'b0;
  logic [31:0]        rd;
  logic [31:0]        csr_mepc;
  logic [31:0]        csr_mtvec;
  logic               int_pend;
  logic               illegal;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mip;
  logic [63:0] m_mcycle;

  csr_trap_unit #(.NUM_IRQ(NUM_IRQ), .MTVEC_RST(MTVEC_RST)) dut (
    .CLK(clk), .RST(rst), .IRQ(irq), .ADDR(addr), .OP(op), .WD(wd), .PC(pc),
    .INT_TAKEN(int_taken), .MRET(mret), .RD(rd), .CSR_MEPC(csr_mepc),
    .CSR_MTVEC(csr_mtvec), .INT_PEND(int_pend), .ILLEGAL(illegal)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mstatus = 0; m_mie = 0; m_mtvec = MTVEC_RST; m_mscratch = 0;
    m_mepc = 0; m_mcause = 0; m_mip = 0; m_mcycle = 0;
  endtask

  function automatic logic [31:0] model_read(logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip;
      12'hB00: return m_mcycle[31:0];
      12'hB80: return m_mcycle[63:32];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic model_illegal(logic [11:0] a, logic [1:0] o);
    logic ok;
    ok = (a == 12'h300) || (a == 12'h304) || (a == 12'h305) || (a == 12'h340) ||
         (a == 12'h341) || (a == 12'h342) || (a == 12'hB00) || (a == 12'hB80);
    return (o != 2'b00) && !ok;
  endfunction

  function automatic logic model_pend();
    return m_mstatus[3] && ((m_mip & m_mie) != 0);
  endfunction

  // Applies one clock edge's worth of architectural effects to the model.
  task automatic model_step();
    logic [31:0] oldv, nv;
    logic wr, pend, bump;
    pend = model_pend();
    wr   = (op != 2'b00) && !model_illegal(addr, op) && !int_taken;
    bump = 1'b1;
    if (int_taken) begin
      m_mepc = pc & ~32'h3;
      if (pend) begin
        for (int i = NUM_IRQ - 1; i >= 0; i--)
          if (m_mip[i] && m_mie[i]) m_mcause = 32'h8000_0000 + i;
      end
      m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
    end else begin
      if (wr) begin
        oldv = model_read(addr);
        nv = (op == 2'b01) ? wd : (op == 2'b10) ? (oldv | wd) : (oldv & ~wd);
        case (addr)
          12'h300: m_mstatus = nv & 32'h88;
          12'h304: m_mie = nv & IRQ_MASK;
          12'h305: m_mtvec = nv;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc = nv & ~32'h3;
          12'h342: m_mcause = nv & 32'h8000_000F;
          12'hB00: begin m_mcycle[31:0] = nv; bump = 1'b0; end
          12'hB80: begin m_mcycle[63:32] = nv; bump = 1'b0; end
          default: ;
        endcase
      end
      if (mret) m_mstatus = (m_mstatus[7] ? 32'h8 : 32'h0) | 32'h80;
    end
    if (bump) m_mcycle = m_mcycle + 1;
    m_mip = 32'(irq);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
  endtask

  task automatic csr_op(logic [11:0] a, logic [1:0] o, logic [31:0] d);
    addr = a; op = o; wd = d;
    tick();
    op = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    addr = 12'h7C0;
    tick();
    checks++; if (int_pend !== 1'b0) begin failures++; $display("[TB] FAIL reset_int_pend got %0b want 0", int_pend); end
    checks++; if (csr_mepc !== 32'h0) begin failures++; $display("[TB] FAIL reset_mepc got %h want 0", csr_mepc); end
    checks++; if (csr_mtvec !== MTVEC_RST) begin failures++; $display("[TB] FAIL reset_mtvec got %h want %h", csr_mtvec, MTVEC_RST); end
    checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL reset_rd_unmapped got %h want 0", rd); end
    @(negedge clk);
    rst = 1'b0;
    addr = 12'hB00;
    #1;
    checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL mcycle_before_edge got %h want 0", rd); end
    tick();
    checks++; if (rd !== 32'h1) begin failures++; $display("[TB] FAIL mcycle_first_edge got %h want 1", rd); end
  endtask

  task automatic test_irq_pending();
    csr_op(12'h305, 2'b01, 32'h100);
    csr_op(12'h304, 2'b10, 32'h4);
    csr_op(12'h300, 2'b10, 32'h8);
    irq = 4'h4;
    #1;
    checks++; if (int_pend !== 1'b0) begin failures++; $display("[TB] FAIL irq_latency got %0b want 0", int_pend); end
    tick();
    checks++; if (int_pend !== 1'b1) begin failures++; $display("[TB] FAIL irq_pending got %0b want 1", int_pend); end
    checks++; if (csr_mtvec !== 32'h100) begin failures++; $display("[TB] FAIL mtvec_write got %h want 100", csr_mtvec); end
  endtask

  task automatic test_trap();
    pc = 32'h2002; int_taken = 1'b1;
    tick();
    int_taken = 1'b0;
    addr = 12'h342; #1;
    checks++; if (csr_mepc !== 32'h2000) begin failures++; $display("[TB] FAIL trap_mepc got %h want 2000", csr_mepc); end
    checks++; if (rd !== 32'h8000_0002) begin failures++; $display("[TB] FAIL trap_mcause got %h want 80000002", rd); end
    checks++; if (int_pend !== 1'b0) begin failures++; $display("[TB] FAIL trap_int_pend got %0b want 0", int_pend); end
    addr = 12'h300; #1;
    checks++; if (rd !== 32'h80) begin failures++; $display("[TB] FAIL trap_mstatus got %h want 80", rd); end
  endtask

  task automatic test_priority_cause();
    csr_op(12'h304, 2'b01, 32'h6);
    irq = 4'h6;
    csr_op(12'h300, 2'b10, 32'h8);
    checks++; if (int_pend !== 1'b1) begin failures++; $display("[TB] FAIL prio_pending got %0b want 1", int_pend); end
    pc = 32'h2400; int_taken = 1'b1;
    tick();
    int_taken = 1'b0;
    addr = 12'h342; #1;
    checks++; if (rd !== 32'h8000_0001) begin failures++; $display("[TB] FAIL prio_mcause got %h want 80000001", rd); end
    mret = 1'b1;
    tick();
    mret = 1'b0;
    addr = 12'h300; #1;
    checks++; if (rd !== 32'h88) begin failures++; $display("[TB] FAIL mret_mstatus got %h want 88", rd); end
  endtask

  task automatic test_back_to_back();
    csr_op(12'h340, 2'b01, 32'h1234);
    addr = 12'h340; op = 2'b01; wd = 32'hCAFE; pc = 32'h3000; int_taken = 1'b1;
    tick();
    op = 2'b00; int_taken = 1'b0; #1;
    checks++; if (rd !== 32'h1234) begin failures++; $display("[TB] FAIL trap_drops_csr_op got %h want 1234", rd); end
    checks++; if (csr_mepc !== 32'h3000) begin failures++; $display("[TB] FAIL b2b_mepc got %h want 3000", csr_mepc); end
    int_taken = 1'b1; mret = 1'b1;
    tick();
    int_taken = 1'b0; mret = 1'b0;
    addr = 12'h300; #1;
    checks++; if (rd[3] !== 1'b0) begin failures++; $display("[TB] FAIL trap_beats_mret_mie got %0b want 0", rd[3]); end
    checks++; if (rd !== m_mstatus) begin failures++; $display("[TB] FAIL trap_beats_mret_mstatus got %h want %h", rd, m_mstatus); end
  endtask

  task automatic test_mcycle_wrap();
    csr_op(12'hB00, 2'b01, 32'hFFFF_FFFF);
    csr_op(12'hB80, 2'b01, 32'h0);
    tick();
    addr = 12'hB80; #1;
    checks++; if (rd !== 32'h1) begin failures++; $display("[TB] FAIL mcycleh_carry got %h want 1", rd); end
    addr = 12'hB00; #1;
    checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL mcycle_wrap got %h want 0", rd); end
    addr = 12'h344; op = 2'b11; wd = 32'hFFFF_FFFF; #1;
    checks++; if (illegal !== 1'b1) begin failures++; $display("[TB] FAIL mip_write_illegal got %0b want 1", illegal); end
    tick();
    op = 2'b00; #1;
    checks++; if (rd !== 32'h6) begin failures++; $display("[TB] FAIL mip_unchanged got %h want 6", rd); end
    addr = 12'h7C0; op = 2'b01; #1;
    checks++; if (illegal !== 1'b1) begin failures++; $display("[TB] FAIL unmapped_illegal got %0b want 1", illegal); end
    op = 2'b00; #1;
    checks++; if (illegal !== 1'b0) begin failures++; $display("[TB] FAIL no_op_legal got %0b want 0", illegal); end
  endtask

  task automatic test_async_reset();
    csr_op(12'h300, 2'b10, 32'h8);
    checks++; if (int_pend !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset_pending got %0b want 1", int_pend); end
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    addr = 12'h344;
    #1;
    checks++; if (int_pend !== 1'b0) begin failures++; $display("[TB] FAIL async_int_pend got %0b want 0", int_pend); end
    checks++; if (csr_mepc !== 32'h0) begin failures++; $display("[TB] FAIL async_mepc got %h want 0", csr_mepc); end
    checks++; if (csr_mtvec !== MTVEC_RST) begin failures++; $display("[TB] FAIL async_mtvec got %h want %h", csr_mtvec, MTVEC_RST); end
    checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL async_mip got %h want 0", rd); end
    int_taken = 1'b1; mret = 1'b1; addr = 12'h305; op = 2'b01; wd = 32'hABCD_0000;
    tick();
    int_taken = 1'b0; mret = 1'b0; op = 2'b00; #1;
    checks++; if (csr_mtvec !== MTVEC_RST) begin failures++; $display("[TB] FAIL reset_overrides_ops got %h want %h", csr_mtvec, MTVEC_RST); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [11:0] pool [10];
    pool = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344, 12'hB00, 12'hB80, 12'h7C0};
    tick();
    for (int n = 0; n < 400; n++) begin
      addr      = pool[$urandom_range(0, 9)];
      op        = 2'($urandom_range(0, 3));
      wd        = $urandom;
      pc        = $urandom;
      irq       = NUM_IRQ'($urandom);
      int_taken = ($urandom_range(0, 5) == 0);
      mret      = ($urandom_range(0, 6) == 0);
      #1;
      checks++; if (rd !== model_read(addr)) begin failures++; $display("[TB] FAIL rand_rd n=%0d addr=%h got %h want %h", n, addr, rd, model_read(addr)); end
      checks++; if (illegal !== model_illegal(addr, op)) begin failures++; $display("[TB] FAIL rand_illegal n=%0d got %0b want %0b", n, illegal, model_illegal(addr, op)); end
      checks++; if (int_pend !== model_pend()) begin failures++; $display("[TB] FAIL rand_int_pend n=%0d got %0b want %0b", n, int_pend, model_pend()); end
      checks++; if (csr_mepc !== m_mepc) begin failures++; $display("[TB] FAIL rand_mepc n=%0d got %h want %h", n, csr_mepc, m_mepc); end
      checks++; if (csr_mtvec !== m_mtvec) begin failures++; $display("[TB] FAIL rand_mtvec n=%0d got %h want %h", n, csr_mtvec, m_mtvec); end
      tick();
    end
    op = 2'b00; int_taken = 1'b0; mret = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_irq_pending();
    test_trap();
    test_priority_cause();
    test_back_to_back();
    test_mcycle_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csr_trap_unit.md
CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 4, number of level-sensitive interrupt lines (legal 1..16).
REQ-002 SHALL have parameter MTVEC_RST, default 32'h0, reset value of mtvec.
REQ-003 SHALL have one clock and a reset that is asynchronous and active-high, with ports named CLK and RST, listed first.
REQ-004 SHALL have port CLK  in  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port RST  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have port IRQ  in  NUM_IRQ  interrupt request lines, level-sensitive.
REQ-007 SHALL have port ADDR  in  12  CSR address.
REQ-008 SHALL have port OP  in  2  CSR operation: 00 none, 01 write, 10 set bits, 11 clear bits.
REQ-009 SHALL have port WD  in  32  CSR operand.
REQ-010 SHALL have port PC  in  32  PC of the instruction being trapped.
REQ-011 SHALL have port INT_TAKEN  in  1  core accepts the pending interrupt this cycle.
REQ-012 SHALL have port MRET  in  1  core executes mret this cycle.
REQ-013 SHALL have port RD  out  32  combinational read data, pre-update value.
REQ-014 SHALL have port CSR_MEPC  out  32  return address.
REQ-015 SHALL have port CSR_MTVEC  out  32  trap vector.
REQ-016 SHALL have port INT_PEND  out  1  interrupt request to the core.
REQ-017 SHALL have port ILLEGAL  out  1  combinational; OP!=00 to an unmapped or read-only address.

Function
REQ-018 SHALL implement these CSRs:
- mstatus 0x300: MIE bit 3, MPIE bit 7, other bits read 0.
- mie 0x304: bits [NUM_IRQ-1:0], others read 0.
- mtvec 0x305: 32 bits, RW.
- mscratch 0x340: 32 bits, RW.
- mepc 0x341: bits [1:0] forced 0.
- mcause 0x342: bit 31 interrupt flag, bits [3:0] cause.
- mip 0x344: read-only, bits [NUM_IRQ-1:0].
- mcycle 0xB00, mcycleh 0xB80: 64-bit counter halves, RW.
REQ-019 SHALL compute new value = WD (01), old|WD (10), old&~WD (11); unimplemented bits unaffected.
REQ-020 SHALL drive RD with the current value of the addressed CSR regardless of OP; unmapped address -> RD=0.
REQ-021 SHALL ignore writes to mip and to unmapped addresses (no state change), asserting ILLEGAL that cycle.
REQ-022 SHALL register IRQ into mip every cycle (one-cycle latency, no latching; mip follows IRQ level).
REQ-023 SHALL drive INT_PEND = mstatus.MIE & |(mip & mie), combinational from registered state.
REQ-024 On INT_TAKEN SHALL, in one cycle: mepc<=PC&~3; mcause<={1, 27'b0, lowest index i with mip[i]&mie[i]}; MPIE<=MIE; MIE<=0.
REQ-025 SHALL leave mcause unchanged if INT_TAKEN asserts while INT_PEND=0, still performing the other REQ-024 updates.
REQ-026 On MRET SHALL set MIE<=MPIE, MPIE<=1.
REQ-027 INT_TAKEN SHALL take priority over MRET and over any CSR op in the same cycle; the losing op is dropped entirely.
REQ-028 MRET with a CSR op in the same cycle: the CSR op SHALL apply first, and MRET SHALL override MIE/MPIE.
REQ-029 SHALL increment mcycle by 1 every cycle, wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-030 A write to mcycle or mcycleh SHALL replace that half, suppressing the increment of the full 64-bit counter that cycle.
REQ-031 SHALL drive CSR_MEPC and CSR_MTVEC directly from the mepc and mtvec registers.

Reset
REQ-032 While RST=1 SHALL asynchronously force mtvec=MTVEC_RST and all other CSRs, including mip and mcycle, to 0.
REQ-033 After reset SHALL output INT_PEND=0, CSR_MEPC=0, CSR_MTVEC=MTVEC_RST, RD=0 when ADDR is unmapped.
REQ-034 Reset asserted mid-cycle SHALL override any simultaneous INT_TAKEN, MRET or CSR op.
REQ-035 mcycle SHALL first reach 1 one clock edge after RST deasserts.

Verification
REQ-036 Bench SHALL check: write mtvec 0x100, set mie=0x4, set mstatus=0x8, drive IRQ=0x4 -> INT_PEND=1 one cycle later.
REQ-037 Bench SHALL check: INT_TAKEN with PC=0x2002 -> mepc=0x2000, mcause=0x8000_0002, mstatus=0x80, INT_PEND=0.
REQ-038 Bench SHALL check: IRQ=0x6 with mie=0x6 and INT_TAKEN -> mcause cause=1; then MRET -> mstatus=0x88.
REQ-039 Bench SHALL check: INT_TAKEN with OP=01 to mscratch in the same cycle -> mscratch unchanged; MRET with INT_TAKEN -> MIE=0.
REQ-040 Bench SHALL check: write mcycle=0xFFFF_FFFF, mcycleh=0 -> next cycle mcycleh=1, mcycle=0; OP=11 to mip -> ILLEGAL=1, mip unchanged.
REQ-041 Bench SHALL check: assert RST asynchronously between edges while IRQ active -> all outputs at reset values immediately, INT_PEND=0.
